// File: rtl/keccak_perm_arbiter_if.sv
// Signal bundle between the Absorb/Squeeze engines, the permutation arbiter and the shared core.
// The arbiter uses the slave view; the engines and the core together form the master side.
interface keccak_perm_arbiter_if #(
  parameter int STATE_WIDTH = 1600,
  parameter int CNT_W       = 16
);
  logic                   req0;
  logic                   req1;
  logic [STATE_WIDTH-1:0] state_in0;
  logic [STATE_WIDTH-1:0] state_in1;
  logic                   gnt0;
  logic                   gnt1;
  logic                   done0;
  logic                   done1;
  logic [STATE_WIDTH-1:0] state_out;
  logic                   core_start;
  logic [STATE_WIDTH-1:0] core_state_in;
  logic                   core_done;
  logic [STATE_WIDTH-1:0] core_state_out;
  logic                   busy;
  logic                   owner;
  logic                   timeout_err;
  logic [CNT_W-1:0]       perm_cnt0;
  logic [CNT_W-1:0]       perm_cnt1;

  modport slave (
    input  req0, req1, state_in0, state_in1, core_done, core_state_out,
    output gnt0, gnt1, done0, done1, state_out, core_start, core_state_in,
           busy, owner, timeout_err, perm_cnt0, perm_cnt1
  );

  modport master (
    output req0, req1, state_in0, state_in1, core_done, core_state_out,
    input  gnt0, gnt1, done0, done1, state_out, core_start, core_state_in,
           busy, owner, timeout_err, perm_cnt0, perm_cnt1
  );
endinterface

// File: rtl/keccak_perm_arbiter.sv
// Round-robin sharing of one Keccak-f[1600] core between the Absorb (0) and Squeeze (1) engines,
// with input capture at grant, start/done sequencing, result return and a sticky watchdog.
module keccak_perm_arbiter #(
  parameter int STATE_WIDTH = 1600,
  parameter int TIMEOUT     = 64,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  keccak_perm_arbiter_if.slave bus
);

  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                 state_q, state_d;
  logic                   owner_q;
  logic                   last_srv_q;
  logic [STATE_WIDTH-1:0] in_buf_q;
  logic [STATE_WIDTH-1:0] state_out_q;
  logic [WD_W-1:0]        wd_q;
  logic                   timeout_err_q;
  logic                   tmo_hit_q;

  logic [1:0]             req_vec;
  logic                   win;
  logic                   grant_en;
  logic                   wd_inc;
  logic                   capture;
  logic                   expire;
  logic                   resp_fire;
  logic                   busy;
  logic                   core_start;
  logic [1:0]             gnt_vec;
  logic [1:0]             done_vec;
  logic [1:0][CNT_W-1:0]  perm_cnt;

  assign req_vec = {bus.req1, bus.req0};
  // On a tie the requester that was not served last wins; otherwise the lone requester wins.
  assign win     = (&req_vec) ? ~last_srv_q : req_vec[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_en   = 1'b0;
    wd_inc     = 1'b0;
    capture    = 1'b0;
    expire     = 1'b0;
    resp_fire  = 1'b0;
    busy       = 1'b1;
    core_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (|req_vec) begin
          grant_en = 1'b1;
          state_d  = S_START;
        end
      end
      S_START: begin
        core_start = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (bus.core_done) begin
          capture = 1'b1;
          state_d = S_RESP;
        end else begin
          wd_inc = 1'b1;
          if (wd_q == WD_LAST) begin
            expire  = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        resp_fire = 1'b1;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath: the winner's state is frozen in in_buf at grant, so the engine may move on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q       <= 1'b0;
      last_srv_q    <= 1'b1;
      in_buf_q      <= '0;
      state_out_q   <= '0;
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
      tmo_hit_q     <= 1'b0;
    end else begin
      if (grant_en) begin
        owner_q   <= win;
        in_buf_q  <= win ? bus.state_in1 : bus.state_in0;
        wd_q      <= '0;
        tmo_hit_q <= 1'b0;
      end
      if (wd_inc) begin
        wd_q <= wd_q + WD_W'(1);
      end
      if (capture) begin
        state_out_q <= bus.core_state_out;
      end
      if (expire) begin
        timeout_err_q <= 1'b1;
        tmo_hit_q     <= 1'b1;
      end
      if (resp_fire) begin
        last_srv_q <= owner_q;
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    logic             mine;
    logic [CNT_W-1:0] cnt_q;

    assign mine         = (owner_q == 1'(gi));
    assign gnt_vec[gi]  = busy & mine;
    assign done_vec[gi] = resp_fire & mine;
    assign perm_cnt[gi] = cnt_q;

    // Timed-out permutations produced no result and are not counted.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
      end else if (done_vec[gi] && !tmo_hit_q && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.gnt0          = gnt_vec[0];
  assign bus.gnt1          = gnt_vec[1];
  assign bus.done0         = done_vec[0];
  assign bus.done1         = done_vec[1];
  assign bus.state_out     = state_out_q;
  assign bus.core_start    = core_start;
  assign bus.core_state_in = in_buf_q;
  assign bus.busy          = busy;
  assign bus.owner         = owner_q;
  assign bus.timeout_err   = timeout_err_q;
  assign bus.perm_cnt0     = perm_cnt[0];
  assign bus.perm_cnt1     = perm_cnt[1];

endmodule

// File: tb/tb_keccak_perm_arbiter.sv
// Directed bench for keccak_perm_arbiter: a vector table of single permutations plus
// hand-written sequences for ties, fairness, input latching, watchdog and mid-flight reset.
module tb_keccak_perm_arbiter;

  localparam int SW = 1600;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  keccak_perm_arbiter_if #(.STATE_WIDTH(SW), .CNT_W(CW)) bus ();

  keccak_perm_arbiter #(.STATE_WIDTH(SW), .TIMEOUT(64), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          r0;
    bit          r1;
    int          lat;
    logic [63:0] s0;
    logic [63:0] s1;
    bit          who;
  } vec_t;

  vec_t vecs[7];

  int total = 0;
  int bad   = 0;

  // core model controls (lat 0 = core never answers)
  int             core_lat  = 1;
  int             stray_req = 0;
  int             stray_ack = 0;
  int             core_cd   = 0;
  logic [SW-1:0]  core_held = '0;

  // monitor counters
  int cyc = 0, n_start = 0, n_done0 = 0, n_done1 = 0, n_gnt0 = 0, n_gnt1 = 0;
  int start_who[$];
  int start_cyc[$];
  int done_cyc[$];

  // scratch used by the main sequence
  int            b_start, b_done, b_gnt0, b_gnt1, fi, di, first;
  bit            seen, exp_last;
  logic [CW-1:0] exp_cnt0, exp_cnt1;
  logic [SW-1:0] exp_st, prev_out;

  function automatic logic [SW-1:0] pat(input logic [63:0] s);
    logic [SW-1:0] p;
    for (int i = 0; i < SW / 64; i++) p[i*64 +: 64] = s ^ 64'(i * 64'h0101);
    return p;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_st(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got low64 %h expected low64 %h", nm, act[63:0], exp[63:0]);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (bus.done0 || bus.done1) ok = 1'b1;
    end
    check("done_within_budget", 64'(ok), 64'd1);
  endtask

  // Core model: answers core_state_in ^ 1 core_lat cycles after core_start.
  initial begin
    bus.core_done      = 1'b0;
    bus.core_state_out = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.core_done      = 1'b0;
      bus.core_state_out = {SW{1'b1}};
      if (reset) begin
        core_cd = 0;
      end else if (bus.core_start) begin
        core_cd   = core_lat;
        core_held = bus.core_state_in ^ SW'(1);
      end else if (core_cd > 0) begin
        core_cd--;
        if (core_cd == 0) begin
          bus.core_done      = 1'b1;
          bus.core_state_out = core_held;
        end
      end
      if (stray_ack != stray_req) begin
        stray_ack     = stray_req;
        bus.core_done = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.core_start) begin
        n_start++;
        start_who.push_back(int'(bus.gnt1));
        start_cyc.push_back(cyc);
      end
      if (bus.done0) begin n_done0++; done_cyc.push_back(cyc); end
      if (bus.done1) begin n_done1++; done_cyc.push_back(cyc); end
      if (bus.gnt0) n_gnt0++;
      if (bus.gnt1) n_gnt1++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 24, 64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_0000_0001, 1'b0};
    vecs[1] = '{1'b0, 1'b1,  5, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b1};
    vecs[2] = '{1'b1, 1'b1,  3, 64'hAAAA_0000_AAAA_0000, 64'h0000_BBBB_0000_BBBB, 1'b0};
    vecs[3] = '{1'b1, 1'b1,  7, 64'hC0C0_C0C0_C0C0_C0C0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1};
    vecs[4] = '{1'b1, 1'b1,  1, 64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b0};
    vecs[5] = '{1'b1, 1'b0,  2, 64'h0000_0000_0000_00FF, 64'hFFFF_0000_0000_0000, 1'b0};
    vecs[6] = '{1'b1, 1'b1,  9, 64'h5A5A_5A5A_0000_0000, 64'h0000_0000_A5A5_A5A5, 1'b1};

    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.state_in0 = '0;
    bus.state_in1 = '0;
    exp_cnt0 = '0;
    exp_cnt1 = '0;

    // Reset values
    repeat (3) tick();
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_gnt", 64'({bus.gnt1, bus.gnt0}), 64'd0);
    check("rst_done", 64'({bus.done1, bus.done0}), 64'd0);
    check("rst_core_start", 64'(bus.core_start), 64'd0);
    check("rst_timeout_err", 64'(bus.timeout_err), 64'd0);
    check("rst_owner", 64'(bus.owner), 64'd0);
    check_st("rst_state_out", bus.state_out, '0);
    check_st("rst_core_state_in", bus.core_state_in, '0);
    check("rst_perm_cnt0", 64'(bus.perm_cnt0), 64'd0);
    check("rst_perm_cnt1", 64'(bus.perm_cnt1), 64'd0);
    reset = 1'b0;
    tick();

    // Simultaneous requests straight out of reset: 0 first, then 1
    bus.state_in0 = pat(64'hAB00_0000_0000_0001);
    bus.state_in1 = pat(64'hCD00_0000_0000_0002);
    core_lat = 24;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    tick();
    check("tie_gnt_k1", 64'({bus.gnt1, bus.gnt0}), 64'd1);
    check("tie_core_start_k1", 64'(bus.core_start), 64'd1);
    check("tie_busy_k1", 64'(bus.busy), 64'd1);
    tick();
    check("tie_core_start_k2", 64'(bus.core_start), 64'd0);
    wait_done(100, seen);
    check("tie_first_done", 64'({bus.done1, bus.done0}), 64'd1);
    check_st("tie_first_state", bus.state_out, pat(64'hAB00_0000_0000_0001) ^ SW'(1));
    $display("txn tie0: owner=%0d out=%h", bus.owner, bus.state_out[63:0]);
    bus.req0 = 1'b0;
    wait_done(100, seen);
    check("tie_second_done", 64'({bus.done1, bus.done0}), 64'd2);
    check_st("tie_second_state", bus.state_out, pat(64'hCD00_0000_0000_0002) ^ SW'(1));
    $display("txn tie1: owner=%0d out=%h", bus.owner, bus.state_out[63:0]);
    bus.req1 = 1'b0;
    repeat (4) tick();
    exp_cnt0 = exp_cnt0 + 1'b1;
    exp_cnt1 = exp_cnt1 + 1'b1;
    exp_last = 1'b1;
    check("tie_starts", 64'(n_start), 64'd2);
    if (start_who.size() >= 2 && done_cyc.size() >= 1) begin
      check("tie_order0", 64'(start_who[0]), 64'd0);
      check("tie_order1", 64'(start_who[1]), 64'd1);
      check("tie_idle_gap", 64'(start_cyc[1] - done_cyc[0]), 64'd2);
    end
    check("tie_perm_cnt0", 64'(bus.perm_cnt0), 64'(exp_cnt0));
    check("tie_perm_cnt1", 64'(bus.perm_cnt1), 64'(exp_cnt1));

    // Table of single permutations
    for (int v = 0; v < 7; v++) begin
      b_start = n_start;
      b_done  = n_done0 + n_done1;
      b_gnt0  = n_gnt0;
      b_gnt1  = n_gnt1;
      bus.state_in0 = pat(vecs[v].s0);
      bus.state_in1 = pat(vecs[v].s1);
      core_lat = vecs[v].lat;
      bus.req0 = vecs[v].r0;
      bus.req1 = vecs[v].r1;
      wait_done(100, seen);
      exp_st = pat(vecs[v].who ? vecs[v].s1 : vecs[v].s0) ^ SW'(1);
      check($sformatf("v%0d_done", v), 64'({bus.done1, bus.done0}), vecs[v].who ? 64'd2 : 64'd1);
      check($sformatf("v%0d_owner", v), 64'(bus.owner), 64'(vecs[v].who));
      check_st($sformatf("v%0d_state_out", v), bus.state_out, exp_st);
      $display("txn v%0d: req=%0d%0d owner=%0d out=%h", v, vecs[v].r1, vecs[v].r0,
               bus.owner, bus.state_out[63:0]);
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      repeat (4) tick();
      if (vecs[v].who) exp_cnt1 = exp_cnt1 + 1'b1;
      else             exp_cnt0 = exp_cnt0 + 1'b1;
      exp_last = vecs[v].who;
      check($sformatf("v%0d_starts", v), 64'(n_start - b_start), 64'd1);
      check($sformatf("v%0d_dones", v), 64'(n_done0 + n_done1 - b_done), 64'd1);
      check($sformatf("v%0d_loser_gnt", v),
            64'(vecs[v].who ? (n_gnt0 - b_gnt0) : (n_gnt1 - b_gnt1)), 64'd0);
      check($sformatf("v%0d_perm_cnt0", v), 64'(bus.perm_cnt0), 64'(exp_cnt0));
      check($sformatf("v%0d_perm_cnt1", v), 64'(bus.perm_cnt1), 64'(exp_cnt1));
    end

    // Fairness: both hold req for 8 permutations
    fi = start_who.size();
    di = done_cyc.size();
    b_start = n_start;
    first = exp_last ? 0 : 1;
    core_lat = 3;
    bus.state_in0 = pat(64'h0000_1111_0000_1111);
    bus.state_in1 = pat(64'h2222_0000_2222_0000);
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    for (int p = 0; p < 8; p++) begin
      wait_done(100, seen);
      $display("txn fair%0d: owner=%0d out=%h", p, bus.owner, bus.state_out[63:0]);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (4) tick();
    check("fair_starts", 64'(n_start - b_start), 64'd8);
    for (int p = 0; p < 8 && fi + p < start_who.size(); p++)
      check($sformatf("fair_order%0d", p), 64'(start_who[fi+p]), 64'(first ^ (p & 1)));
    for (int p = 0; p < 7 && fi + p + 1 < start_cyc.size() && di + p < done_cyc.size(); p++)
      check($sformatf("fair_gap%0d", p), 64'(start_cyc[fi+p+1] - done_cyc[di+p]), 64'd2);
    exp_cnt0 = exp_cnt0 + 4'd4;
    exp_cnt1 = exp_cnt1 + 4'd4;
    exp_last = 1'(first ^ 1);
    check("fair_perm_cnt0", 64'(bus.perm_cnt0), 64'(exp_cnt0));
    check("fair_perm_cnt1", 64'(bus.perm_cnt1), 64'(exp_cnt1));

    // Input latching: state_in1 changes right after grant
    bus.state_in1 = pat(64'h7777_AAAA_7777_AAAA);
    core_lat = 6;
    bus.req1 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (bus.gnt1) seen = 1'b1;
    end
    check("latch_gnt1_seen", 64'(seen), 64'd1);
    bus.state_in1 = pat(64'h9999_5555_9999_5555);
    tick();
    check_st("latch_core_state_in", bus.core_state_in, pat(64'h7777_AAAA_7777_AAAA));
    wait_done(100, seen);
    prev_out = pat(64'h7777_AAAA_7777_AAAA) ^ SW'(1);
    check_st("latch_state_out", bus.state_out, prev_out);
    $display("txn latch: owner=%0d out=%h", bus.owner, bus.state_out[63:0]);
    bus.req1 = 1'b0;
    repeat (3) tick();
    exp_cnt1 = exp_cnt1 + 1'b1;
    check("latch_perm_cnt1", 64'(bus.perm_cnt1), 64'(exp_cnt1));

    // Stray core_done while IDLE is ignored
    b_start = n_start;
    b_done  = n_done0 + n_done1;
    stray_req++;
    repeat (4) tick();
    check("stray_busy", 64'(bus.busy), 64'd0);
    check("stray_no_start", 64'(n_start - b_start), 64'd0);
    check("stray_no_done", 64'(n_done0 + n_done1 - b_done), 64'd0);
    check_st("stray_state_out", bus.state_out, prev_out);

    // Watchdog: core never answers
    b_done = n_done0 + n_done1;
    core_lat = 0;
    bus.state_in0 = pat(64'hBAD0_BAD0_BAD0_BAD0);
    bus.req0 = 1'b1;
    wait_done(150, seen);
    check("wd_done", 64'({bus.done1, bus.done0}), 64'd1);
    check("wd_timeout_err", 64'(bus.timeout_err), 64'd1);
    check_st("wd_state_out_kept", bus.state_out, prev_out);
    if (start_cyc.size() > 0 && done_cyc.size() > 0)
      check("wd_latency", 64'(done_cyc[$] - start_cyc[$]), 64'd65);
    $display("txn watchdog: owner=%0d timeout_err=%0d", bus.owner, bus.timeout_err);
    bus.req0 = 1'b0;
    repeat (4) tick();
    check("wd_single_done", 64'(n_done0 + n_done1 - b_done), 64'd1);
    check("wd_perm_cnt0", 64'(bus.perm_cnt0), 64'(exp_cnt0));

    // Normal service after a timeout
    core_lat = 4;
    bus.state_in0 = pat(64'h0BAD_F00D_0BAD_F00D);
    bus.req0 = 1'b1;
    wait_done(100, seen);
    check("post_wd_done", 64'({bus.done1, bus.done0}), 64'd1);
    check_st("post_wd_state", bus.state_out, pat(64'h0BAD_F00D_0BAD_F00D) ^ SW'(1));
    $display("txn post_wd: owner=%0d out=%h", bus.owner, bus.state_out[63:0]);
    bus.req0 = 1'b0;
    repeat (3) tick();
    exp_cnt0 = exp_cnt0 + 1'b1;
    check("post_wd_perm_cnt0", 64'(bus.perm_cnt0), 64'(exp_cnt0));
    check("post_wd_timeout_sticky", 64'(bus.timeout_err), 64'd1);

    // Asynchronous reset while in WAIT
    core_lat = 0;
    bus.state_in1 = pat(64'h3333_3333_3333_3333);
    bus.req1 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (bus.core_start) seen = 1'b1;
    end
    check("arst_started", 64'(seen), 64'd1);
    repeat (3) tick();
    check("arst_pre_busy", 64'(bus.busy), 64'd1);
    b_done = n_done0 + n_done1;
    reset = 1'b1;
    #1;
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_gnt", 64'({bus.gnt1, bus.gnt0}), 64'd0);
    check("arst_core_start", 64'(bus.core_start), 64'd0);
    check("arst_done", 64'({bus.done1, bus.done0}), 64'd0);
    check("arst_timeout_err", 64'(bus.timeout_err), 64'd0);
    check("arst_perm_cnt0", 64'(bus.perm_cnt0), 64'd0);
    check("arst_perm_cnt1", 64'(bus.perm_cnt1), 64'd0);
    check_st("arst_state_out", bus.state_out, '0);
    repeat (2) tick();
    bus.req1 = 1'b0;
    reset = 1'b0;
    repeat (5) tick();
    check("arst_no_done", 64'(n_done0 + n_done1 - b_done), 64'd0);
    check("arst_idle", 64'(bus.busy), 64'd0);
    $display("txn reset_in_wait: busy=%0d", bus.busy);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
